// File: rtl/freq_sched.sv
// freq_sched: shares one frequency-count block between two symbol sources.
// Arbitrates round-robin per block, drives the counter's start/data/start_done
// handshake, caps each block at MAX_LEN counted symbols, and holds off the next
// block until the coding stage signals cod_done.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   sX_req/valid/data/last (X=0,1)  source session request and symbol stream
//   sX_ready, sX_gnt                per-source accept strobe and session grant
//   fc_start, fc_data, fc_start_done  frequency-counter protocol (fc_data=4'hF when idle)
//   cod_done                        coding stage consumed the counts
//   busy                            a session is in progress
//   sym_err, trunc_err              illegal-symbol / block-truncation pulses
module freq_sched #(
   parameter int unsigned MAX_LEN = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s0_req,
   input  logic       s0_valid,
   input  logic [3:0] s0_data,
   input  logic       s0_last,
   output logic       s0_ready,
   output logic       s0_gnt,
   input  logic       s1_req,
   input  logic       s1_valid,
   input  logic [3:0] s1_data,
   input  logic       s1_last,
   output logic       s1_ready,
   output logic       s1_gnt,
   output logic       fc_start,
   output logic [3:0] fc_data,
   output logic       fc_start_done,
   input  logic       cod_done,
   output logic       busy,
   output logic       sym_err,
   output logic       trunc_err
);

   typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, WAIT_CODE} state_t;

   // Length value at which the current accept is the last one counted.
   localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);

   state_t     state, state_nx;
   logic       gnt_id, gnt_nx;
   logic       last_gnt, last_gnt_nx;
   logic [7:0] len, len_nx;

   logic       sel_valid, sel_last, ready_int, accept;
   logic [3:0] sel_data;

   // Granted source's stream, selected once so the FSM is source-agnostic.
   assign sel_valid = gnt_id ? s1_valid : s0_valid;
   assign sel_last  = gnt_id ? s1_last  : s0_last;
   assign sel_data  = gnt_id ? s1_data  : s0_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt_id   <= 1'b0;
         last_gnt <= 1'b1;
         len      <= '0;
      end else begin
         state    <= state_nx;
         gnt_id   <= gnt_nx;
         last_gnt <= last_gnt_nx;
         len      <= len_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      gnt_nx        = gnt_id;
      last_gnt_nx   = last_gnt;
      len_nx        = len;
      ready_int     = 1'b0;
      accept        = 1'b0;
      fc_start      = 1'b0;
      fc_data       = 4'hF;
      fc_start_done = 1'b0;
      trunc_err     = 1'b0;
      case (state)
         IDLE: begin
            if (s0_req || s1_req) begin
               // Tie goes to the source not granted last; last_gnt resets to 1 so S0 wins first.
               gnt_nx      = (s0_req && s1_req) ? ~last_gnt : s1_req;
               last_gnt_nx = gnt_nx;
               len_nx      = '0;
               state_nx    = START;
            end
         end
         START: begin
            fc_start = 1'b1;
            state_nx = STREAM;
         end
         STREAM: begin
            ready_int = 1'b1;
            if (sel_valid) begin
               accept  = 1'b1;
               fc_data = sel_data;
               len_nx  = len + 8'd1;
               if (sel_last) begin
                  fc_start_done = 1'b1;
                  state_nx      = WAIT_CODE;
               end else if (len == LEN_LAST) begin
                  fc_start_done = 1'b1;
                  trunc_err     = 1'b1;
                  state_nx      = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Remainder of an over-long block is consumed but never forwarded.
            ready_int = 1'b1;
            if (sel_valid) begin
               accept = 1'b1;
               if (sel_last) state_nx = WAIT_CODE;
            end
         end
         WAIT_CODE: begin
            if (cod_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign s0_gnt   = busy & ~gnt_id;
   assign s1_gnt   = busy &  gnt_id;
   assign s0_ready = ready_int & ~gnt_id;
   assign s1_ready = ready_int &  gnt_id;
   assign sym_err  = accept & (sel_data > 4'd9);

endmodule

// File: tb/tb_freq_sched.sv
// Directed bench for freq_sched (MAX_LEN=4): per-cycle vector table with
// hand-computed outputs, plus a bounded-wait latency sequence.
module tb_freq_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s0_req, s0_valid, s0_last, s0_ready, s0_gnt;
   logic       s1_req, s1_valid, s1_last, s1_ready, s1_gnt;
   logic [3:0] s0_data, s1_data, fc_data;
   logic       fc_start, fc_start_done, cod_done, busy, sym_err, trunc_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   freq_sched #(.MAX_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_req(s0_req), .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last),
      .s0_ready(s0_ready), .s0_gnt(s0_gnt),
      .s1_req(s1_req), .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last),
      .s1_ready(s1_ready), .s1_gnt(s1_gnt),
      .fc_start(fc_start), .fc_data(fc_data), .fc_start_done(fc_start_done),
      .cod_done(cod_done), .busy(busy), .sym_err(sym_err), .trunc_err(trunc_err)
   );

   // One record per clock cycle. sXc = {req, valid, last}.
   // ef = {s0_ready, s0_gnt, s1_ready, s1_gnt, fc_start, fc_start_done, busy, sym_err, trunc_err}
   typedef struct {
      string      name;
      logic       rst;
      logic [2:0] s0c;
      logic [3:0] s0d;
      logic [2:0] s1c;
      logic [3:0] s1d;
      logic       cod;
      logic [8:0] ef;
      logic [3:0] ed;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string n, input logic r, input logic [2:0] s0c, input logic [3:0] s0d,
                      input logic [2:0] s1c, input logic [3:0] s1d, input logic cod,
                      input logic [8:0] ef, input logic [3:0] ed);
      vec_t v;
      v.name = n; v.rst = r; v.s0c = s0c; v.s0d = s0d; v.s1c = s1c; v.s1d = s1d;
      v.cod = cod; v.ef = ef; v.ed = ed;
      tbl.push_back(v);
   endtask

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      rst_n = v.rst;
      {s0_req, s0_valid, s0_last} = v.s0c; s0_data = v.s0d;
      {s1_req, s1_valid, s1_last} = v.s1c; s1_data = v.s1d;
      cod_done = v.cod;
      @(negedge clk);
      chk(v.name,
          {19'd0, s0_ready, s0_gnt, s1_ready, s1_gnt, fc_start, fc_start_done, busy, sym_err, trunc_err, fc_data},
          {19'd0, v.ef, v.ed});
      @(posedge clk); #1;
   endtask

   localparam logic [8:0] IDL   = 9'b000000000;
   localparam logic [8:0] S0ST  = 9'b010010100;
   localparam logic [8:0] S1ST  = 9'b000110100;
   localparam logic [8:0] S0STR = 9'b110000100;
   localparam logic [8:0] S1STR = 9'b001100100;
   localparam logic [8:0] S0DN  = 9'b110001100;
   localparam logic [8:0] S1DN  = 9'b001101100;
   localparam logic [8:0] S0WT  = 9'b010000100;
   localparam logic [8:0] S1WT  = 9'b000100100;

   initial begin
      int cnt;
      // Reset
      add("reset",        0, 3'b000, 0, 3'b000, 0, 0, IDL, 4'hF);
      // Single block S0: 3,3,7 (valid offered during START must not be taken)
      add("a_req",        1, 3'b100, 0, 3'b000, 0, 0, IDL, 4'hF);
      add("a_start",      1, 3'b110, 3, 3'b000, 0, 0, S0ST, 4'hF);
      add("a_sym3a",      1, 3'b110, 3, 3'b000, 0, 0, S0STR, 4'h3);
      add("a_sym3b",      1, 3'b010, 3, 3'b000, 0, 0, S0STR, 4'h3);
      add("a_sym7_last",  1, 3'b011, 7, 3'b000, 0, 0, S0DN, 4'h7);
      add("a_wait",       1, 3'b000, 0, 3'b000, 0, 0, S0WT, 4'hF);
      add("a_cod",        1, 3'b000, 0, 3'b000, 0, 1, S0WT, 4'hF);
      add("a_stray_cod",  1, 3'b000, 0, 3'b000, 0, 1, IDL, 4'hF);
      add("a_idle",       1, 3'b000, 0, 3'b000, 0, 0, IDL, 4'hF);
      // Bubbles on S1; S0 request during S1's WAIT_CODE is held off
      add("b_req",        1, 3'b000, 0, 3'b100, 0, 0, IDL, 4'hF);
      add("b_start",      1, 3'b000, 0, 3'b000, 0, 0, S1ST, 4'hF);
      add("b_sym5",       1, 3'b000, 0, 3'b010, 5, 0, S1STR, 4'h5);
      add("b_gap1",       1, 3'b000, 0, 3'b000, 5, 0, S1STR, 4'hF);
      add("b_gap2",       1, 3'b000, 0, 3'b000, 5, 0, S1STR, 4'hF);
      add("b_sym5_last",  1, 3'b000, 0, 3'b011, 5, 0, S1DN, 4'h5);
      add("b_wait_cod",   1, 3'b110, 1, 3'b000, 0, 1, S1WT, 4'hF);
      // Round robin with both requesting: S0, S1, S0
      add("r_tie1",       1, 3'b100, 0, 3'b100, 0, 0, IDL, 4'hF);
      add("r_start1",     1, 3'b100, 0, 3'b100, 0, 0, S0ST, 4'hF);
      add("r_s0_sym",     1, 3'b111, 1, 3'b111, 2, 0, S0DN, 4'h1);
      add("r_wait1",      1, 3'b111, 1, 3'b111, 2, 1, S0WT, 4'hF);
      add("r_tie2",       1, 3'b100, 0, 3'b100, 0, 0, IDL, 4'hF);
      add("r_start2",     1, 3'b100, 0, 3'b100, 0, 0, S1ST, 4'hF);
      add("r_s1_sym",     1, 3'b111, 1, 3'b111, 2, 0, S1DN, 4'h2);
      add("r_wait2",      1, 3'b100, 0, 3'b100, 0, 1, S1WT, 4'hF);
      add("r_tie3",       1, 3'b100, 0, 3'b100, 0, 0, IDL, 4'hF);
      add("r_start3",     1, 3'b100, 0, 3'b100, 0, 0, S0ST, 4'hF);
      add("r_s0_sym8",    1, 3'b111, 8, 3'b111, 2, 0, S0DN, 4'h8);
      add("r_wait3",      1, 3'b000, 0, 3'b000, 0, 1, S0WT, 4'hF);
      // Truncation at MAX_LEN=4, then drain to last
      add("t_req",        1, 3'b100, 0, 3'b000, 0, 0, IDL, 4'hF);
      add("t_start",      1, 3'b000, 0, 3'b000, 0, 0, S0ST, 4'hF);
      add("t_sym1",       1, 3'b010, 1, 3'b000, 0, 0, S0STR, 4'h1);
      add("t_sym2",       1, 3'b010, 2, 3'b000, 0, 0, S0STR, 4'h2);
      add("t_sym3",       1, 3'b010, 3, 3'b000, 0, 0, S0STR, 4'h3);
      add("t_sym4_trunc", 1, 3'b010, 4, 3'b000, 0, 0, 9'b110001101, 4'h4);
      add("t_drain5",     1, 3'b010, 5, 3'b000, 0, 0, S0STR, 4'hF);
      add("t_drain6_last",1, 3'b011, 6, 3'b000, 0, 0, S0STR, 4'hF);
      add("t_wait_cod",   1, 3'b000, 0, 3'b000, 0, 1, S0WT, 4'hF);
      // Illegal symbol counts toward len; illegal symbol during DRAIN
      add("i_req",        1, 3'b000, 0, 3'b100, 0, 0, IDL, 4'hF);
      add("i_start",      1, 3'b000, 0, 3'b000, 0, 0, S1ST, 4'hF);
      add("i_symC",       1, 3'b000, 0, 3'b010, 4'hC, 0, 9'b001100110, 4'hC);
      add("i_sym1",       1, 3'b000, 0, 3'b010, 1, 0, S1STR, 4'h1);
      add("i_sym2",       1, 3'b000, 0, 3'b010, 2, 0, S1STR, 4'h2);
      add("i_sym3_trunc", 1, 3'b000, 0, 3'b010, 3, 0, 9'b001101101, 4'h3);
      add("i_drainF",     1, 3'b000, 0, 3'b011, 4'hF, 0, 9'b001100110, 4'hF);
      add("i_wait_cod",   1, 3'b000, 0, 3'b000, 0, 1, S1WT, 4'hF);
      // last together with len==MAX_LEN-1: normal end, no trunc; 9 is legal
      add("j_req",        1, 3'b100, 0, 3'b000, 0, 0, IDL, 4'hF);
      add("j_start",      1, 3'b000, 0, 3'b000, 0, 0, S0ST, 4'hF);
      add("j_sym0a",      1, 3'b010, 0, 3'b000, 0, 0, S0STR, 4'h0);
      add("j_sym0b",      1, 3'b010, 0, 3'b000, 0, 0, S0STR, 4'h0);
      add("j_sym0c",      1, 3'b010, 0, 3'b000, 0, 0, S0STR, 4'h0);
      add("j_sym9_last",  1, 3'b011, 9, 3'b000, 0, 0, S0DN, 4'h9);
      add("j_wait_cod",   1, 3'b000, 0, 3'b000, 0, 1, S0WT, 4'hF);
      // Reset mid-STREAM; afterwards tie goes to S0 again, then S1 alone
      add("z_req",        1, 3'b100, 0, 3'b000, 0, 0, IDL, 4'hF);
      add("z_start",      1, 3'b000, 0, 3'b000, 0, 0, S0ST, 4'hF);
      add("z_sym1",       1, 3'b010, 1, 3'b000, 0, 0, S0STR, 4'h1);
      add("z_sym2",       1, 3'b010, 2, 3'b000, 0, 0, S0STR, 4'h2);
      add("z_reset",      0, 3'b011, 3, 3'b000, 0, 0, IDL, 4'hF);
      add("z_tie",        1, 3'b100, 0, 3'b100, 0, 0, IDL, 4'hF);
      add("z_tie_start",  1, 3'b000, 0, 3'b000, 0, 0, S0ST, 4'hF);
      add("z_sym4_last",  1, 3'b011, 4, 3'b000, 0, 0, S0DN, 4'h4);
      add("z_wait_cod",   1, 3'b000, 0, 3'b000, 0, 1, S0WT, 4'hF);
      add("z_s1_req",     1, 3'b000, 0, 3'b100, 0, 0, IDL, 4'hF);
      add("z_s1_start",   1, 3'b000, 0, 3'b000, 0, 0, S1ST, 4'hF);
      add("z_s1_last",    1, 3'b000, 0, 3'b011, 5, 0, S1DN, 4'h5);
      add("z_s1_wait",    1, 3'b000, 0, 3'b000, 0, 1, S1WT, 4'hF);
      add("z_idle",       1, 3'b000, 0, 3'b000, 0, 0, IDL, 4'hF);

      foreach (tbl[i]) apply(tbl[i]);

      // Latency: req first seen in IDLE, fc_start exactly one cycle later (bounded wait)
      s0_req = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (fc_start) break;
         cnt++;
         @(posedge clk); #1;
         s0_req = 1'b0;
      end
      chk("lat_start_cycles", cnt, 1);
      @(posedge clk); #1;
      s0_req = 1'b0; s0_valid = 1'b1; s0_data = 4'd6; s0_last = 1'b1;
      @(negedge clk);
      chk("lat_one_sym_done", {fc_start_done, fc_data}, {1'b1, 4'h6});
      @(posedge clk); #1;
      s0_valid = 1'b0; s0_last = 1'b0;
      cnt = 0;
      while (busy && cnt < 8) begin
         cod_done = 1'b1;
         @(posedge clk); #1;
         cod_done = 1'b0;
         cnt++;
      end
      @(negedge clk);
      chk("lat_cod_to_idle", {busy, 8'(cnt)}, {1'b0, 8'd1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
